mcu_spi_master: RTL and testbench
=================================

# mcu_spi_master

SPI master that drives the 24-bit `{command, address, data}` frame link between the FPGA and a command-queue slave. It takes words from a valid/ready request port and shifts them out MSB-first in SPI mode 0, and it captures the word returned on MISO in the same frame. When no requests are pending it issues NOPE polls to drain the slave's outbound queue. Received non-NOPE words are presented on a one-cycle strobe for a downstream command decoder.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCK half-period in `clk` cycles; must be ≥ 2.
- `CS_GAP`, default 4: `clk` cycles `spi_cs_n` stays high between frames; must be ≥ 1.
- `POLL_INTERVAL`, default 1024: idle `clk` cycles before an automatic NOPE poll; must be ≥ 1.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `tx_data` in 24: frame to send, `{cmd[23:16], addr[15:8], data[7:0]}`.
- `tx_valid` in 1: request valid.
- `tx_ready` out 1: master idle and able to accept a request.
- `rx_data` out 24: last received non-NOPE frame.
- `rx_valid` out 1: one-cycle strobe qualifying `rx_data`.
- `spi_sck` out 1: SPI clock. Idles low.
- `spi_mosi` out 1: serial data out.
- `spi_miso` in 1: serial data in.
- `spi_cs_n` out 1: chip select, active low.
- `busy` out 1: high from frame start through the end of GAP.

## Operation
- The FSM has five states: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- **IDLE**
  - `tx_ready` = 1.
  - A request is accepted when `tx_valid` and `tx_ready` are both high. `tx_data` is latched into the shift register and the FSM goes to SETUP.
  - Otherwise the poll counter increments. At `POLL_INTERVAL-1` the master loads `24'hFF0000` and goes to SETUP.
  - If the previous received frame was non-NOPE, a poll starts on the first IDLE cycle with no pending request (fast drain).
  - A pending request always takes priority over a poll.
  - The poll counter clears at every frame start.
- **SETUP**
  - `spi_cs_n` = 0, `spi_mosi` = bit 23, `spi_sck` = 0.
  - Lasts `CLK_DIV` cycles.
- **XFER**: 24 bit periods. Each bit period is:
  - a high phase: `spi_sck` = 1 for `CLK_DIV` cycles;
  - then a low phase: `spi_sck` = 0 for `CLK_DIV` cycles.
  - `spi_miso` is registered once. The registered value is shifted into the receive register on the last cycle of each high phase.
  - The next MOSI bit is presented on the first low-phase cycle (the falling edge).
  - A 5-bit counter tracks bits 0–23 and does not wrap.
- **HOLD**
  - `spi_cs_n` = 0, `spi_sck` = 0.
  - Lasts `CLK_DIV` cycles.
- **GAP**
  - `spi_cs_n` = 1.
  - On the first GAP cycle, `rx_valid` pulses and `rx_data` updates if received `[23:16]` ≠ `8'hFF`. NOPE frames are discarded silently.
  - Lasts `CS_GAP` cycles, then the FSM returns to IDLE.
- `tx_valid` is ignored whenever `tx_ready` = 0.
- Reset values:
  - `spi_cs_n` = 1, `spi_sck` = 0, `spi_mosi` = 0;
  - `tx_ready` = 0 during reset, 1 on the first cycle after reset;
  - `rx_valid` = 0, `rx_data` = 0, `busy` = 0;
  - all counters and the fast-drain flag are cleared.
- Reset mid-frame aborts the frame: CS is deasserted the next cycle and no `rx_valid` is produced for that frame.

## Timing
- Frame length is `CLK_DIV·50 + CS_GAP` cycles from the acceptance edge to `tx_ready` high again. With the defaults this is 204 cycles.
- `spi_cs_n` falls on the cycle after acceptance.
- The first SCK rising edge comes `CLK_DIV` cycles after CS falls.
- `rx_valid` fires `CLK_DIV·50 + 1` cycles after acceptance.
- Idle poll: the first poll frame starts `POLL_INTERVAL` cycles after entering IDLE.

## Test plan
- **Single send.** Reset, then `tx_data` = `0x0500AB` with `tx_valid` = 1 and loopback `spi_miso` = 0.
  - MOSI bits sampled at SCK rising edges must equal `0x0500AB`, MSB first.
  - Exactly 24 rising edges.
  - `tx_ready` is low for 204 cycles.
- **Response capture.** The slave model returns `0xFA0C55` while the master sends `0x010000`.
  - `rx_valid` pulses once.
  - `rx_data` = `0xFA0C55`.
- **NOPE filter.** The slave returns `0xFF0000`.
  - No `rx_valid`.
  - `rx_data` keeps its previous value.
- **Auto poll and fast drain.** With no requests, the slave has 3 queued words followed by NOPE.
  - The first poll starts 1024 idle cycles after reset.
  - The next 3 polls start back-to-back after each GAP.
  - Exactly 3 `rx_valid` pulses.
  - The following poll waits 1024 cycles.
- **Priority.** Assert `tx_valid` on the same cycle the poll counter expires.
  - The request frame is sent, not `0xFF0000`.
- **Reset mid-frame.** Assert `reset` at bit 10 of a frame.
  - Next cycle: `spi_cs_n` = 1, `spi_sck` = 0.
  - No `rx_valid`.
  - `tx_ready` = 1 on the first cycle after `reset` deasserts.

Source files
------------

// File: rtl/mcu_spi_master.sv
// mcu_spi_master: SPI mode-0 master for 24-bit {cmd,addr,data} frames.
// Idle NOPE polls drain the slave queue; received non-NOPE words are strobed out.
module mcu_spi_master #(
   parameter int CLK_DIV       = 4,
   parameter int CS_GAP        = 4,
   parameter int POLL_INTERVAL = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [23:0] rx_data,
   output logic        rx_valid,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_n,
   output logic        busy
);
   localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CW = $clog2(CMAX);
   localparam int PW = $clog2(POLL_INTERVAL + 1);
   localparam logic [23:0] NOPE = 24'hFF0000;
   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            hi_q, hi_d;
   logic [4:0]      bit_q, bit_d;
   logic [PW-1:0]   poll_q, poll_d;
   logic            drain_q, drain_d;
   logic [23:0]     shift_q, shift_d;
   logic [23:0]     rx_q, rx_d;
   logic [23:0]     rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            miso_q;
   logic            div_end, gap_end, poll_hit, start;
   assign div_end  = cnt_q == CW'(CLK_DIV - 1);
   assign gap_end  = cnt_q == CW'(CS_GAP - 1);
   assign poll_hit = poll_q == PW'(POLL_INTERVAL - 1);
   // a pending request wins; otherwise fast drain or poll timeout start a NOPE frame
   assign start    = tx_valid || drain_q || poll_hit;
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CW'(1);
      hi_d       = hi_q;
      bit_d      = bit_q;
      poll_d     = '0;
      drain_d    = drain_q;
      shift_d    = shift_q;
      rx_d       = rx_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            poll_d = start ? '0 : poll_q + PW'(1);
            if (start) begin
               state_d = SETUP;
               drain_d = 1'b0;
               shift_d = tx_valid ? tx_data : NOPE;
            end
         end
         SETUP: if (div_end) begin
            state_d = XFER;
            cnt_d   = '0;
            hi_d    = 1'b1;
            bit_d   = '0;
         end
         XFER: if (div_end) begin
            cnt_d = '0;
            hi_d  = !hi_q;
            // end of high phase: capture MISO and advance MOSI at the falling edge
            if (hi_q) begin
               shift_d = {shift_q[22:0], 1'b0};
               rx_d    = {rx_q[22:0], miso_q};
            end else if (bit_q == 5'd23) begin
               state_d = HOLD;
               hi_d    = 1'b0;
            end else begin
               bit_d = bit_q + 5'd1;
            end
         end
         HOLD: if (div_end) begin
            state_d = GAP;
            cnt_d   = '0;
            if (rx_q[23:16] != 8'hFF) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rx_q;
               drain_d    = 1'b1;
            end
         end
         GAP: if (gap_end) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hi_q       <= 1'b0;
         bit_q      <= '0;
         poll_q     <= '0;
         drain_q    <= 1'b0;
         shift_q    <= '0;
         rx_q       <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         bit_q      <= bit_d;
         poll_q     <= poll_d;
         drain_q    <= drain_d;
         shift_q    <= shift_d;
         rx_q       <= rx_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= spi_miso;
      end
   end
   assign tx_ready = (state_q == IDLE) && !reset;
   assign busy     = state_q != IDLE;
   assign spi_cs_n = !(state_q inside {SETUP, XFER, HOLD});
   assign spi_sck  = (state_q == XFER) && hi_q;
   assign spi_mosi = shift_q[23];
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_mcu_spi_master.sv
// tb_mcu_spi_master: directed bench with a mode-0 slave model returning queued words.
module tb_mcu_spi_master;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready, rx_valid, spi_sck, spi_mosi, spi_miso, spi_cs_n, busy;
   logic [23:0] rx_data;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [23:0] resp_mem [0:15];
   int          wr_i = 0;
   int          rd_i = 0;
   logic [23:0] sl_sh = '0;
   logic        cs_prev = 1'b1;
   logic [23:0] mosi_sh = '0;
   int          sck_n = 0;
   mcu_spi_master dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .busy(busy)
   );
   always #5 clk = ~clk;
   // slave: loads next queued word (NOPE when empty) at CS fall, shifts on SCK fall
   assign spi_miso = sl_sh[23];
   always @(spi_cs_n or negedge spi_sck) begin
      if (spi_cs_n === 1'b0 && cs_prev !== 1'b0) begin
         if (rd_i < wr_i) begin
            sl_sh = resp_mem[rd_i];
            rd_i++;
         end else begin
            sl_sh = 24'hFF0000;
         end
      end else if (spi_cs_n === 1'b0 && spi_sck === 1'b0) begin
         sl_sh = {sl_sh[22:0], 1'b0};
      end
      cs_prev = spi_cs_n;
   end
   always @(negedge spi_cs_n or posedge spi_sck) begin
      if (spi_sck === 1'b1) begin
         sck_n++;
         mosi_sh = {mosi_sh[22:0], spi_mosi};
      end else begin
         sck_n = 0;
         mosi_sh = '0;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push_resp(input logic [23:0] w);
      resp_mem[wr_i] = w;
      wr_i++;
   endtask
   task automatic send(input logic [23:0] w, input logic [23:0] resp,
                       output int low, output int rxn, output int rxat);
      int n;
      n = 0;
      while (tx_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      push_resp(resp);
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      low  = 0;
      rxn  = 0;
      rxat = -1;
      while (tx_ready !== 1'b1 && low < 400) begin
         low++;
         if (rx_valid === 1'b1) begin
            rxn++;
            rxat = low;
         end
         @(negedge clk);
      end
   endtask
   task automatic watch_frame(output int wait_n, output int rxn);
      int low;
      wait_n = 0;
      rxn    = 0;
      low    = 0;
      while (spi_cs_n !== 1'b0 && wait_n < 3000) begin
         @(negedge clk);
         wait_n++;
      end
      while (tx_ready !== 1'b1 && low < 400) begin
         if (rx_valid === 1'b1) rxn++;
         low++;
         @(negedge clk);
      end
   endtask
   initial begin
      int low, rxn, rxat, wn, tot;
      repeat (3) @(negedge clk);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_cs_n", spi_cs_n, 1);
      check("rst_sck", spi_sck, 0);
      check("rst_mosi", spi_mosi, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", tx_ready, 1);
      // single send, slave returns all zeros
      send(24'h0500AB, 24'h000000, low, rxn, rxat);
      check("t1_mosi", mosi_sh, 24'h0500AB);
      check("t1_sck_edges", sck_n, 24);
      check("t1_ready_low", low, 204);
      check("t1_rxv_count", rxn, 1);
      check("t1_rxv_cycle", rxat, 201);
      check("t1_rx_data", rx_data, 24'h000000);
      watch_frame(wn, rxn);
      check("t1_drain_start", wn, 1);
      check("t1_drain_mosi", mosi_sh, 24'hFF0000);
      check("t1_drain_rxv", rxn, 0);
      // response capture, then the drain poll sees NOPE
      send(24'h010000, 24'hFA0C55, low, rxn, rxat);
      check("t2_mosi", mosi_sh, 24'h010000);
      check("t2_rxv_count", rxn, 1);
      check("t2_rx_data", rx_data, 24'hFA0C55);
      watch_frame(wn, rxn);
      check("t2_drain_start", wn, 1);
      check("t2_nope_rxv", rxn, 0);
      check("t2_nope_rx_data", rx_data, 24'hFA0C55);
      send(24'h020000, 24'hFF0000, low, rxn, rxat);
      check("t3_nope_rxv", rxn, 0);
      check("t3_nope_rx_data", rx_data, 24'hFA0C55);
      check("t3_ready_low", low, 204);
      // auto poll and fast drain from reset
      reset = 1'b1;
      repeat (2) @(negedge clk);
      push_resp(24'h123456);
      push_resp(24'hABCDEF);
      push_resp(24'h00FF00);
      reset = 1'b0;
      watch_frame(wn, rxn);
      check("t4_first_poll_wait", wn, 1024);
      check("t4_first_poll_mosi", mosi_sh, 24'hFF0000);
      check("t4_first_rx_data", rx_data, 24'h123456);
      tot = rxn;
      for (int i = 0; i < 3; i++) begin
         watch_frame(wn, rxn);
         check("t4_drain_wait", wn, 1);
         tot += rxn;
      end
      check("t4_rxv_total", tot, 3);
      check("t4_last_rx_data", rx_data, 24'h00FF00);
      watch_frame(wn, rxn);
      check("t4_idle_poll_wait", wn, 1024);
      check("t4_idle_poll_rxv", rxn, 0);
      // request on the exact cycle the poll counter expires
      repeat (1023) @(negedge clk);
      send(24'h0A0B0C, 24'hFF0000, low, rxn, rxat);
      check("t5_priority_mosi", mosi_sh, 24'h0A0B0C);
      check("t5_ready_low", low, 204);
      // reset during bit 10
      push_resp(24'h345678);
      tx_data  = 24'h0C0D0E;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wn = 0;
      while (sck_n != 11 && wn < 500) begin
         @(negedge clk);
         wn++;
      end
      check("t6_reached_bit10", sck_n, 11);
      reset = 1'b1;
      @(negedge clk);
      check("t6_cs_n", spi_cs_n, 1);
      check("t6_sck", spi_sck, 0);
      check("t6_busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);
      check("t6_tx_ready", tx_ready, 1);
      rxn = 0;
      repeat (300) begin
         if (rx_valid === 1'b1) rxn++;
         @(negedge clk);
      end
      check("t6_no_rxv", rxn, 0);
      check("t6_rx_data", rx_data, 24'h000000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
